pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Parametrised next-generation fetch PC sequencer at the head of the fetch stage.
- Produces one aligned fetch group per accepted request over a valid/ready handshake, with a per-slot validity mask.
- Handles delay-slot-aware branch prediction, including a predicted branch sitting in the last slot of a group.
- Applies exception and misprediction redirects immediately, even while fetch is stalled.

Parameters:
RESET_BASE, 32'hBFC00000, PC loaded on reset
FETCH_NUM, 4, instructions per fetch group; power of two, 1..8
OFF (localparam), $clog2(FETCH_NUM)+2, group alignment bit position

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
fetch_ready  input  1  fetch stage accepts current group
fetch_valid  output  1  fetch_pc/fetch_mask valid
fetch_pc  output  32  current fetch address
fetch_mask  output  FETCH_NUM  slot i valid when i >= fetch_pc[OFF-1:2]
redirect  output  1  registered one-cycle pulse: previous cycle applied exception/mispredict redirect
predict_valid  input  1  taken prediction for current group
predict_slot  input  max(1,OFF-2)  slot index of predicted branch
predict_vaddr  input  32  predicted target
resolved_valid  input  1  branch resolved
resolved_mispredict  input  1  resolution disagrees with prediction
resolved_taken  input  1  actual direction
resolved_pc  input  32  branch PC
resolved_target  input  32  actual taken target
except_valid  input  1  exception redirect
except_vec  input  32  exception vector
fetch_misaligned  output  1  see Optional Feature

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_BASE, fetch_valid=0, redirect=0, state NORMAL, saved_target=0, fetch_misaligned=0.
- First clk edge after rst falls: fetch_valid=1. It stays 1 until the next reset.
- fire = fetch_valid & fetch_ready. Without fire and without a redirect, all state holds.
- Sequential next PC: {fetch_pc[31:OFF]+1, OFF'b0}, modulo 2^32. 0xFFFFFFF0 wraps to 0x00000000.
- State NORMAL, on fire with predict_valid:
  - predict_slot < FETCH_NUM-1 (delay slot in same group): next pc = predict_vaddr.
  - predict_slot == FETCH_NUM-1, or FETCH_NUM==1: next pc = sequential; saved_target <= predict_vaddr; state -> DS_PENDING.
- State DS_PENDING, on fire: next pc = saved_target; state -> NORMAL. predict_valid is ignored in this state.
- predict_* inputs are ignored when there is no fire.
- Mispredict (resolved_valid & resolved_mispredict): next pc = resolved_taken ? resolved_target : resolved_pc+32'd8.
  - Applied regardless of fetch_ready. State -> NORMAL, saved_target cleared.
- except_valid: next pc = except_vec. Applied regardless of fetch_ready. State -> NORMAL, saved_target cleared.
- Priority, highest first: except_valid > mispredict > DS_PENDING target > prediction > sequential.
- redirect <= except_valid | (resolved_valid & resolved_mispredict), registered one cycle.
- Redirect targets are loaded unaligned as given. fetch_mask is combinational from fetch_pc[OFF-1:2].
- Reset asserted mid-DS_PENDING or mid-stall: state discarded, reset values apply immediately.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - fetch_misaligned = fetch_valid & (fetch_pc[1:0] != 0).
  - While fetch_misaligned=1, fire does not advance the PC or change state. The group is held until an exception or mispredict redirect.
- Undefined:
  - fetch_misaligned tied 0.
  - Misaligned PCs advance normally; the sequential increment clears the low bits.

Test Plan (FETCH_NUM=4):
1. rst=1 for 2 cycles, then released with fetch_ready=1 -> fetch_valid 0 then 1; fetch_pc 0xBFC00000, 0xBFC00010, 0xBFC00020; mask 4'b1111.
2. Mispredict taken, target 0x80000008 -> redirect=1 next cycle; fetch_pc 0x80000008, mask 4'b1100; then 0x80000010, mask 4'b1111.
3. At 0x80000000, fire with predict slot 1, target 0x80001000 -> next fetch_pc 0x80001000.
4. At 0x80000000, predict slot 3, target 0x80002004 -> fetch_pc 0x80000010 (DS_PENDING); next fire -> 0x80002004, mask 4'b1110.
5. fetch_ready=0 for 3 cycles -> PC holds. Then except_valid with vector 0xBFC00380 and a simultaneous mispredict -> fetch_pc 0xBFC00380, redirect=1.
6. In DS_PENDING, mispredict not-taken with resolved_pc 0x8000000C -> fetch_pc 0x80000014; saved target dropped; following fire -> 0x80000020.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: next-PC sequencer at the head of the fetch stage.
// It emits one aligned fetch group per accepted request, with a per-slot
// validity mask. It handles delay-slot-aware prediction, including a
// predicted branch sitting in the last slot of a group. Exception and
// mispredict redirects take effect at once, even while fetch is stalled.
// Optional build macro: PC_MISALIGN_CHECK_EN. When it is defined, a fetch
// PC that is not word aligned is held until an exception or mispredict
// redirect arrives.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_BASE = 32'hBFC00000,
  parameter int          FETCH_NUM  = 4,
  localparam int         OFF        = $clog2(FETCH_NUM) + 2,
  localparam int         SW         = (OFF - 2 < 1) ? 1 : OFF - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_pc,
  output logic [FETCH_NUM-1:0] fetch_mask,
  output logic                 redirect,
  input  logic                 predict_valid,
  input  logic [SW-1:0]        predict_slot,
  input  logic [31:0]          predict_vaddr,
  input  logic                 resolved_valid,
  input  logic                 resolved_mispredict,
  input  logic                 resolved_taken,
  input  logic [31:0]          resolved_pc,
  input  logic [31:0]          resolved_target,
  input  logic                 except_valid,
  input  logic [31:0]          except_vec,
  output logic                 fetch_misaligned
);

  typedef enum logic {S_NORMAL, S_DS_PENDING} state_t;

  localparam logic [31:0]   GROUP_BYTES = 32'(1) << OFF;
  localparam logic [SW-1:0] LAST_SLOT   = SW'(FETCH_NUM - 1);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_saved;
  logic        r_valid;
  logic        r_redirect;

  logic [31:0] w_seq_pc;
  logic        w_mispredict;
  logic        w_misaligned;
  logic        w_advance;
  logic        w_same_group;

  // Sequential next group: clear the in-group offset, step one group (wraps mod 2^32)
  assign w_seq_pc     = (r_pc & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;
  assign w_mispredict = resolved_valid & resolved_mispredict;
  // Branch in the last slot has its delay slot in the next group
  assign w_same_group = predict_slot < LAST_SLOT;

`ifdef PC_MISALIGN_CHECK_EN
  assign w_misaligned = r_valid & (r_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_advance        = r_valid & fetch_ready & ~w_misaligned;
  assign fetch_misaligned = w_misaligned;
  assign fetch_valid      = r_valid;
  assign fetch_pc         = r_pc;
  assign redirect         = r_redirect;

  generate
    if (FETCH_NUM == 1) begin : g_single
      // A single-slot group is always fully valid
      always_comb fetch_mask = 1'b1;
    end else begin : g_multi
      logic [SW-1:0] w_slot;
      assign w_slot = r_pc[OFF-1:2];
      // Slots before the entry offset belong to the previous path
      always_comb begin
        fetch_mask = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
          fetch_mask[i] = (w_slot <= SW'(i));
        end
      end
    end
  endgenerate

  // PC/state update; priority is exception > mispredict > delay-slot target > prediction > sequential
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_BASE;
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
      r_state    <= S_NORMAL;
      r_saved    <= 32'd0;
    end else begin
      r_valid    <= 1'b1;
      r_redirect <= except_valid | w_mispredict;
      if (except_valid) begin
        r_pc    <= except_vec;
        r_state <= S_NORMAL;
        r_saved <= 32'd0;
      end else if (w_mispredict) begin
        r_pc    <= resolved_taken ? resolved_target : resolved_pc + 32'd8;
        r_state <= S_NORMAL;
        r_saved <= 32'd0;
      end else if (w_advance) begin
        if (r_state == S_DS_PENDING) begin
          r_pc    <= r_saved;
          r_state <= S_NORMAL;
        end else if (predict_valid && w_same_group) begin
          r_pc <= predict_vaddr;
        end else if (predict_valid) begin
          r_pc    <= w_seq_pc;
          r_saved <= predict_vaddr;
          r_state <= S_DS_PENDING;
        end else begin
          r_pc <= w_seq_pc;
        end
      end
    end
  end

endmodule
